// File: rtl/branch_cond_resolver.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_resolver
// Description : Resolves SPARC Bicc branches in ID against the {N,Z,C,V}
//               condition codes. Produces a registered nPC redirect, a kill
//               for the annulled delay-slot instruction, a DCTI-in-slot error
//               pulse, and saturating branch/taken statistics.
//               Build option CC_BYPASS_EN: when defined, the flags being
//               written by the EX instruction are forwarded, so ID never
//               stalls. When undefined, a branch that meets an EX flag write
//               stalls one cycle (WAIT_CC) and resolves on the updated PSR.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_resolver #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              Clr,
    input  logic [3:0]        psr_flags,
    input  logic              ex_setcc,
    input  logic [3:0]        ex_flags,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic [3:0]        id_cond,
    input  logic              id_annul,
    input  logic [ADDR_W-1:0] id_target,
    output logic              stall,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              slot_kill,
    output logic              dcti_err,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_SLOT    = 2'd1;
    localparam logic [1:0]       c_WAIT_CC = 2'd2;
    localparam logic [3:0]       c_COND_BA = 4'b1000;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_annul_pending;
    logic              r_redirect_valid;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic              r_dcti_err;
    logic [CNT_W-1:0]  r_br_count;
    logic [CNT_W-1:0]  r_taken_count;

    logic [3:0]        w_flags;
    logic              w_stall;
    logic              w_cond_base;
    logic              w_taken;
    logic              w_accept;
    logic              w_slot_fill;
    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;

`ifdef CC_BYPASS_EN
    // Forward the flags EX is about to commit; the hazard never stalls
    assign w_flags = ex_setcc ? ex_flags : psr_flags;
    assign w_stall = 1'b0;
`else
    // Only committed flags are visible; a pending EX flag write forces a wait
    logic w_unused_ex_flags;
    assign w_unused_ex_flags = ^ex_flags;
    assign w_flags = psr_flags;
    assign w_stall = (r_state == c_IDLE) & id_valid & id_branch & ex_setcc;
`endif

    assign w_n = w_flags[3];
    assign w_z = w_flags[2];
    assign w_c = w_flags[1];
    assign w_v = w_flags[0];

    // Base condition from cond[2:0]; cond[3] selects the complementary test
    always_comb begin
        w_cond_base = 1'b0;
        case (id_cond[2:0])
            3'd0:    w_cond_base = 1'b0;
            3'd1:    w_cond_base = w_z;
            3'd2:    w_cond_base = w_z | (w_n ^ w_v);
            3'd3:    w_cond_base = w_n ^ w_v;
            3'd4:    w_cond_base = w_c | w_z;
            3'd5:    w_cond_base = w_c;
            3'd6:    w_cond_base = w_n;
            3'd7:    w_cond_base = w_v;
            default: w_cond_base = 1'b0;
        endcase
    end

    assign w_taken     = w_cond_base ^ id_cond[3];
    assign w_accept    = id_valid & id_branch & ~w_stall &
                         ((r_state == c_IDLE) | (r_state == c_WAIT_CC));
    assign w_slot_fill = (r_state == c_SLOT) & id_valid;

    // Next-state selection for the branch / delay-slot sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_stall) begin
                    w_state_nxt = c_WAIT_CC;
                end else if (w_accept) begin
                    w_state_nxt = c_SLOT;
                end
            end
            c_SLOT: begin
                if (id_valid) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_WAIT_CC: begin
                // The stalled branch normally resolves here; if ID no longer
                // holds a branch, fall back to IDLE rather than lock up
                if (w_accept) begin
                    w_state_nxt = c_SLOT;
                end else if (id_valid) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State register and delay-slot annul tracking
    always_ff @(posedge clk) begin
        if (Clr) begin
            r_state         <= c_IDLE;
            r_annul_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                // BA,a annuls its slot even though taken; others only when untaken
                r_annul_pending <= id_annul & (~w_taken | (id_cond == c_COND_BA));
            end else if (w_slot_fill) begin
                r_annul_pending <= 1'b0;
            end
        end
    end

    // Registered redirect pulse and target, plus DCTI-in-slot error pulse
    always_ff @(posedge clk) begin
        if (Clr) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_dcti_err       <= 1'b0;
        end else begin
            r_redirect_valid <= w_accept & w_taken;
            if (w_accept & w_taken) begin
                r_redirect_pc <= id_target;
            end
            r_dcti_err <= w_slot_fill & id_branch;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (Clr) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else if (w_accept) begin
            if (r_br_count != c_CNT_MAX) begin
                r_br_count <= r_br_count + c_CNT_ONE;
            end
            if (w_taken && (r_taken_count != c_CNT_MAX)) begin
                r_taken_count <= r_taken_count + c_CNT_ONE;
            end
        end
    end

    assign stall          = w_stall;
    assign slot_kill      = w_slot_fill & r_annul_pending;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign dcti_err       = r_dcti_err;
    assign br_count       = r_br_count;
    assign taken_count    = r_taken_count;

endmodule
`default_nettype wire
